// File: rtl/pipeline_pkg.sv
// Shared types for the RV32I pipeline hazard controller: forwarding selects,
// memory-handshake FSM states and the forwarding priority rule.
package pipeline_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // M-stage result is younger than W-stage, so it wins when both match.
    function automatic fwd_sel_e fwd_select(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       wr_m,
        input logic [4:0] rd_w,
        input logic       wr_w
    );
        if (wr_m && (rd_m != REG_ZERO) && (rd_m == rs)) return FWD_MEM;
        if (wr_w && (rd_w != REG_ZERO) && (rd_w == rs)) return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline: forwarding,
// load-use and branch hazards, and the handshake with a multi-cycle data memory.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int CNT_WIDTH   = 32,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           Rs1D,
    input  logic [4:0]           Rs2D,
    input  logic [4:0]           Rs1E,
    input  logic [4:0]           Rs2E,
    input  logic [4:0]           RdE,
    input  logic [4:0]           RdM,
    input  logic [4:0]           RdW,
    input  logic                 RegWriteM,
    input  logic                 RegWriteW,
    input  logic                 LoadE,
    input  logic                 PCSrcE,
    input  logic                 MemAccessM,
    input  logic                 MemReadyM,
    output logic                 MemReqM,
    output logic [1:0]           ForwardAE,
    output logic [1:0]           ForwardBE,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 StallE,
    output logic                 StallM,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic                 FlushW,
    output logic                 MemErr,
    output logic [CNT_WIDTH-1:0] StallCnt,
    output logic [CNT_WIDTH-1:0] FlushCnt,
    output logic                 o_dbg_mem_state
);

    localparam int TW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_CNT = TW'(MEM_TIMEOUT);

    mem_state_e    r_state;
    logic [TW-1:0] r_timer;
    logic          r_mem_err;

    logic w_mem_stall;
    logic w_lw_stall;
    logic w_branch;
    logic w_stall_front;

    // Memory handshake: MemReqM is held high from the first cycle of an access
    // until the cycle MemReadyM is seen; that cycle completes the access and the
    // pipeline advances in it. A reset drops MemReqM and abandons the access.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= MEM_IDLE;
            r_timer   <= '0;
            r_mem_err <= 1'b0;
        end else begin
            case (r_state)
                MEM_IDLE: begin
                    if (MemAccessM && !MemReadyM) begin
                        r_state <= MEM_WAIT;
                        r_timer <= TW'(1);
                    end
                end
                MEM_WAIT: begin
                    if (MemReadyM) begin
                        r_state <= MEM_IDLE;
                    end else if (r_timer == TIMEOUT_CNT) begin
                        r_mem_err <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: r_state <= MEM_IDLE;
            endcase
        end
    end

    assign w_mem_stall = !rst && ((r_state == MEM_WAIT) ? !MemReadyM
                                                        : (MemAccessM && !MemReadyM));

    assign w_lw_stall = !rst && LoadE && (RdE != REG_ZERO) &&
                        ((RdE == Rs1D) || (RdE == Rs2D));

    // A memory stall freezes E, so branch and load-use resolve once it releases.
    assign w_branch      = !rst && PCSrcE && !w_mem_stall;
    assign w_stall_front = w_mem_stall || (w_lw_stall && !w_mem_stall);

    assign StallF = w_stall_front;
    assign StallD = w_stall_front;
    assign StallE = w_mem_stall;
    assign StallM = w_mem_stall;

    assign FlushD = rst || w_branch;
    assign FlushE = rst || w_branch || (w_lw_stall && !w_mem_stall);
    assign FlushW = rst || w_mem_stall;

    assign MemReqM = !rst && ((r_state == MEM_WAIT) || MemAccessM);
    assign MemErr  = r_mem_err;

    assign ForwardAE = rst ? FWD_RF : fwd_select(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    assign ForwardBE = rst ? FWD_RF : fwd_select(Rs2E, RdM, RegWriteM, RdW, RegWriteW);

    assign o_dbg_mem_state = r_state;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_stall_front),
        .count (StallCnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_branch),
        .count (FlushCnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed hazard scenarios followed by random traffic,
// every output compared each cycle against a rule-level reference model.
module tb_pipeline_ctrl;

    localparam int CW  = 8;
    localparam int TO  = 4;
    localparam int MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic          RegWriteM, RegWriteW, LoadE, PCSrcE, MemAccessM, MemReadyM;
    logic          MemReqM, StallF, StallD, StallE, StallM;
    logic          FlushD, FlushE, FlushW, MemErr, o_dbg_mem_state;
    logic [1:0]    ForwardAE, ForwardBE;
    logic [CW-1:0] StallCnt, FlushCnt;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    bit m_busy;
    int m_waits;
    bit m_err;
    int m_stall_cnt;
    int m_flush_cnt;
    bit p_mem_stall, p_stall_f, p_flush;

    pipeline_ctrl #(.CNT_WIDTH(CW), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .LoadE(LoadE), .PCSrcE(PCSrcE),
        .MemAccessM(MemAccessM), .MemReadyM(MemReadyM), .MemReqM(MemReqM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .MemErr(MemErr), .StallCnt(StallCnt), .FlushCnt(FlushCnt),
        .o_dbg_mem_state(o_dbg_mem_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Inputs are already applied; compare every output against the model.
    task automatic settle_check();
        bit mem_stall, lw, stall_f;
        #1;
        mem_stall = !rst && (m_busy || MemAccessM) && !MemReadyM;
        lw        = !rst && LoadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        stall_f   = mem_stall || lw;
        chk("StallF", StallF, stall_f);
        chk("StallD", StallD, stall_f);
        chk("StallE", StallE, mem_stall);
        chk("StallM", StallM, mem_stall);
        chk("FlushD", FlushD, rst || (PCSrcE && !mem_stall));
        chk("FlushE", FlushE, rst || (!mem_stall && (PCSrcE || lw)));
        chk("FlushW", FlushW, rst || mem_stall);
        chk("MemReqM", MemReqM, !rst && (m_busy || MemAccessM));
        chk("ForwardAE", ForwardAE, rst ? 2'b00 : ref_fwd(Rs1E));
        chk("ForwardBE", ForwardBE, rst ? 2'b00 : ref_fwd(Rs2E));
        chk("MemErr", MemErr, m_err);
        chk("StallCnt", StallCnt, m_stall_cnt);
        chk("FlushCnt", FlushCnt, m_flush_cnt);
        chk("mem_state", o_dbg_mem_state, m_busy);
        p_mem_stall = mem_stall;
        p_stall_f   = stall_f;
        p_flush     = !rst && PCSrcE && !mem_stall;
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            m_busy = 0; m_waits = 0; m_err = 0; m_stall_cnt = 0; m_flush_cnt = 0;
        end else begin
            if (p_mem_stall) begin
                if (!m_busy) begin
                    m_busy  = 1;
                    m_waits = 0;
                end else begin
                    m_waits++;
                    if (m_waits >= TO) m_err = 1;
                end
            end else begin
                m_busy = 0;
            end
            if (p_stall_f && m_stall_cnt < MAX) m_stall_cnt++;
            if (p_flush && m_flush_cnt < MAX) m_flush_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic cycle();
        settle_check();
        advance();
    endtask

    task automatic clear_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; LoadE = 0; PCSrcE = 0;
        MemAccessM = 0; MemReadyM = 0;
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        @(posedge clk);
        @(negedge clk);

        // Reset state
        settle_check();
        chk("rst_flushD", FlushD, 1);
        chk("rst_stallF", StallF, 0);
        chk("rst_memreq", MemReqM, 0);
        advance();
        rst = 0;

        // Forwarding priority
        RdM = 5; RegWriteM = 1; Rs1E = 5; RdW = 5; RegWriteW = 1;
        settle_check();
        chk("t1_fwd_mem", ForwardAE, 2'b10);
        advance();
        RdM = 0;
        settle_check();
        chk("t1_fwd_wb", ForwardAE, 2'b01);
        advance();
        RegWriteW = 0;
        settle_check();
        chk("t1_fwd_rf", ForwardAE, 2'b00);
        advance();
        clear_inputs();

        // Load-use bubble
        LoadE = 1; RdE = 7; Rs2D = 7;
        settle_check();
        chk("t2_stallF", StallF, 1);
        chk("t2_flushE", FlushE, 1);
        advance();
        chk("t2_stallcnt", StallCnt, 1);
        RdE = 0; Rs2D = 0;
        settle_check();
        chk("t2_r0_stallF", StallF, 0);
        advance();
        clear_inputs();

        // Taken branch
        PCSrcE = 1;
        settle_check();
        chk("t3_flushD", FlushD, 1);
        advance();
        chk("t3_flushcnt", FlushCnt, 1);
        clear_inputs();

        // Multi-cycle memory access with three wait cycles
        MemAccessM = 1;
        for (int i = 0; i < 3; i++) begin
            settle_check();
            chk("t4_stallM", StallM, 1);
            advance();
        end
        MemReadyM = 1;
        settle_check();
        chk("t4_release", StallF, 0);
        chk("t4_req", MemReqM, 1);
        advance();
        chk("t4_stallcnt", StallCnt, 4);
        clear_inputs();

        // Memory timeout, then reset mid-wait
        MemAccessM = 1;
        for (int i = 0; i < 1 + TO; i++) begin
            settle_check();
            chk("t5_noerr", MemErr, 0);
            advance();
        end
        chk("t5_err", MemErr, 1);
        cycle();
        chk("t5_sticky", MemErr, 1);
        rst = 1;
        settle_check();
        chk("t5_rst_req", MemReqM, 0);
        advance();
        rst = 0;
        MemAccessM = 0;
        settle_check();
        chk("t5_err_clr", MemErr, 0);
        chk("t5_idle", o_dbg_mem_state, 0);
        advance();

        // Branch held behind a memory stall
        MemAccessM = 1; PCSrcE = 1;
        for (int i = 0; i < 2; i++) begin
            settle_check();
            chk("t6_flush_held", FlushD, 0);
            advance();
        end
        MemReadyM = 1;
        settle_check();
        chk("t6_flush_rel", FlushD, 1);
        advance();
        chk("t6_flushcnt", FlushCnt, 1);
        clear_inputs();

        // Random traffic; late phase is reset-free so the counters can saturate
        for (int i = 0; i < 1500; i++) begin
            int sel;
            rst       = (i < 250) && ($urandom_range(0, 59) == 0);
            Rs1D      = 5'($urandom_range(0, 7));
            Rs2D      = 5'($urandom_range(0, 7));
            Rs1E      = 5'($urandom_range(0, 7));
            Rs2E      = 5'($urandom_range(0, 7));
            RdE       = 5'($urandom_range(0, 7));
            RdM       = 5'($urandom_range(0, 7));
            RdW       = 5'($urandom_range(0, 7));
            RegWriteM = 1'($urandom_range(0, 1));
            RegWriteW = 1'($urandom_range(0, 1));
            sel       = $urandom_range(0, 3);
            LoadE     = (sel == 1);
            PCSrcE    = (sel == 2);
            MemAccessM = m_busy ? 1'b1 : ($urandom_range(0, 2) == 0);
            MemReadyM  = ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
